// File: rtl/cop0_exc_unit.sv
// Coprocessor-0 exception/interrupt unit: status/cause/EPC registers, trap and eret sequencing.
// Define COP0_TIMER_EN to build the Count/Compare timer; without it those registers read 0.
module cop0_exc_unit #(
  parameter int          NUM_EXC    = 4,
  parameter int          NUM_IRQ    = 6,
  parameter logic [31:0] EXC_VECTOR = 32'h80000180
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mt_en,
  input  logic [4:0]           wreg,
  input  logic [31:0]          wdata,
  input  logic [4:0]           rreg,
  output logic [31:0]          rdata,
  input  logic [NUM_EXC-1:0]   exc_valid,
  input  logic [5*NUM_EXC-1:0] exc_code,
  input  logic [31:0]          exc_pc,
  input  logic [31:0]          exc_badaddr,
  input  logic [NUM_IRQ-1:0]   irq,
  input  logic                 eret,
  output logic                 redirect,
  output logic [31:0]          redirect_pc,
  output logic                 flush,
  output logic                 kernel_mode,
  output logic [31:0]          epc
);

  localparam logic [4:0] R_BADVADDR = 5'd8;
  localparam logic [4:0] R_COUNT    = 5'd9;
  localparam logic [4:0] R_COMPARE  = 5'd11;
  localparam logic [4:0] R_STATUS   = 5'd12;
  localparam logic [4:0] R_CAUSE    = 5'd13;
  localparam logic [4:0] R_EPC      = 5'd14;

  typedef enum logic [1:0] {S_RUN, S_TRAP, S_RET} state_t;

  state_t             state_q, state_d;
  logic [31:0]        badvaddr_q, badvaddr_d;
  logic [31:0]        epc_q, epc_d;
  logic [4:0]         exccode_q, exccode_d;
  logic               ie_q, ie_d, exl_q, exl_d, um_q, um_d;
  logic [7:0]         im_q, im_d;
  logic [1:0]         ip_sw_q, ip_sw_d;
  logic [NUM_IRQ-1:0] irq_q;
  logic [31:0]        count_q, compare_q;
  logic               ti_q;
  logic [5:0]         irq_ext;
  logic [7:0]         ip;
  logic [4:0]         win_code;
  logic               irq_take, accept;

`ifdef COP0_TIMER_EN
  // A Compare write clears TI even when the match fires in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q   <= '0;
      compare_q <= '0;
      ti_q      <= 1'b0;
    end else begin
      count_q <= (mt_en && wreg == R_COUNT) ? wdata : count_q + 32'd1;
      if (mt_en && wreg == R_COMPARE) begin
        compare_q <= wdata;
        ti_q      <= 1'b0;
      end else if (count_q == compare_q) begin
        ti_q <= 1'b1;
      end
    end
  end
`else
  assign count_q   = '0;
  assign compare_q = '0;
  assign ti_q      = 1'b0;
`endif

  always_comb begin
    irq_ext                = '0;
    irq_ext[NUM_IRQ-1:0]   = irq_q;
  end

  assign ip       = {irq_ext[5] | ti_q, irq_ext[4:0], ip_sw_q};
  assign irq_take = ie_q & ~exl_q & (|(ip & im_q));
  assign accept   = (|exc_valid) | irq_take;

  // Scan from the top so the lowest-numbered valid source is left in win_code.
  always_comb begin
    win_code = '0;
    for (int i = NUM_EXC - 1; i >= 0; i--) begin
      if (exc_valid[i]) win_code = exc_code[5*i +: 5];
    end
  end

  always_comb begin
    state_d    = state_q;
    badvaddr_d = badvaddr_q;
    epc_d      = epc_q;
    exccode_d  = exccode_q;
    ie_d       = ie_q;
    exl_d      = exl_q;
    um_d       = um_q;
    im_d       = im_q;
    ip_sw_d    = ip_sw_q;
    if (mt_en) begin
      case (wreg)
        R_BADVADDR: badvaddr_d = wdata;
        R_STATUS: begin
          ie_d  = wdata[0];
          exl_d = wdata[1];
          um_d  = wdata[4];
          im_d  = wdata[15:8];
        end
        R_CAUSE:  ip_sw_d = wdata[9:8];
        R_EPC:    epc_d   = wdata;
        default:  ;
      endcase
    end
    case (state_q)
      S_RUN: begin
        if (accept) begin
          state_d    = S_TRAP;
          exccode_d  = win_code;
          exl_d      = 1'b1;
          badvaddr_d = exc_badaddr;
          if (!exl_q) epc_d = exc_pc;
        end else if (eret) begin
          state_d = S_RET;
          exl_d   = 1'b0;
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_RUN;
      badvaddr_q <= '0;
      epc_q      <= '0;
      exccode_q  <= '0;
      ie_q       <= 1'b0;
      exl_q      <= 1'b1;
      um_q       <= 1'b0;
      im_q       <= '0;
      ip_sw_q    <= '0;
      irq_q      <= '0;
    end else begin
      state_q    <= state_d;
      badvaddr_q <= badvaddr_d;
      epc_q      <= epc_d;
      exccode_q  <= exccode_d;
      ie_q       <= ie_d;
      exl_q      <= exl_d;
      um_q       <= um_d;
      im_q       <= im_d;
      ip_sw_q    <= ip_sw_d;
      irq_q      <= irq;
    end
  end

  always_comb begin
    case (rreg)
      R_BADVADDR: rdata = badvaddr_q;
      R_COUNT:    rdata = count_q;
      R_COMPARE:  rdata = compare_q;
      R_STATUS:   rdata = {16'b0, im_q, 3'b0, um_q, 2'b0, exl_q, ie_q};
      R_CAUSE:    rdata = {1'b0, ti_q, 14'b0, ip, 1'b0, exccode_q, 2'b0};
      R_EPC:      rdata = epc_q;
      default:    rdata = '0;
    endcase
  end

  assign redirect    = (state_q != S_RUN);
  assign flush       = (state_q == S_TRAP);
  assign redirect_pc = (state_q == S_RET) ? epc_q : EXC_VECTOR;
  assign kernel_mode = exl_q | ~um_q;
  assign epc         = epc_q;

endmodule

// File: tb/tb_cop0_exc_unit.sv
// Directed bench for cop0_exc_unit: traps, interrupts, eret, mtc0 collisions, reset, timer option.
module tb_cop0_exc_unit;
  logic        clk = 1'b0;
  logic        reset, mt_en, eret;
  logic [4:0]  wreg, rreg;
  logic [31:0] wdata, rdata, exc_pc, exc_badaddr, redirect_pc, epc;
  logic [3:0]  exc_valid;
  logic [19:0] exc_code;
  logic [5:0]  irq;
  logic        redirect, flush, kernel_mode;
  int          errors = 0;
  int          checks = 0;
  logic [31:0] v;

  cop0_exc_unit dut (
    .clk(clk), .reset(reset), .mt_en(mt_en), .wreg(wreg), .wdata(wdata),
    .rreg(rreg), .rdata(rdata), .exc_valid(exc_valid), .exc_code(exc_code),
    .exc_pc(exc_pc), .exc_badaddr(exc_badaddr), .irq(irq), .eret(eret),
    .redirect(redirect), .redirect_pc(redirect_pc), .flush(flush),
    .kernel_mode(kernel_mode), .epc(epc)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mtc0(input logic [4:0] r, input logic [31:0] d);
    mt_en = 1'b1; wreg = r; wdata = d;
    tick();
    mt_en = 1'b0;
  endtask

  task automatic rd(input logic [4:0] r, output logic [31:0] d);
    rreg = r;
    #1;
    d = rdata;
  endtask

  task automatic clear_ev();
    exc_valid = '0; exc_code = '0; eret = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (redirect !== 1'b0) begin errors++; $display("FAIL rst_redirect got %b exp 0", redirect); end
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL rst_flush got %b exp 0", flush); end
    checks++; if (redirect_pc !== 32'h80000180) begin errors++; $display("FAIL rst_rpc got %h exp 80000180", redirect_pc); end
    checks++; if (kernel_mode !== 1'b1) begin errors++; $display("FAIL rst_kernel got %b exp 1", kernel_mode); end
    rd(5'd12, v); checks++; if (v !== 32'h2) begin errors++; $display("FAIL rst_status got %h exp 00000002", v); end
    rd(5'd13, v); checks++; if (v !== 32'h0) begin errors++; $display("FAIL rst_cause got %h exp 0", v); end
    rd(5'd14, v); checks++; if (v !== 32'h0) begin errors++; $display("FAIL rst_epc got %h exp 0", v); end
    rd(5'd8, v);  checks++; if (v !== 32'h0) begin errors++; $display("FAIL rst_badvaddr got %h exp 0", v); end
    rd(5'd9, v);  checks++; if (v !== 32'h0) begin errors++; $display("FAIL rst_count got %h exp 0", v); end
  endtask

  task automatic test_regs();
`ifdef COP0_TIMER_EN
    mtc0(5'd11, 32'hFFFF_FFF0);
`endif
    mtc0(5'd12, 32'hFFFF_FFFF);
    rd(5'd12, v); checks++; if (v !== 32'h0000_FF13) begin errors++; $display("FAIL status_all got %h exp 0000ff13", v); end
    mtc0(5'd12, 32'h0000_0010);
    checks++; if (kernel_mode !== 1'b0) begin errors++; $display("FAIL user_mode got %b exp 0", kernel_mode); end
    mtc0(5'd12, 32'h0);
    checks++; if (kernel_mode !== 1'b1) begin errors++; $display("FAIL kernel_um0 got %b exp 1", kernel_mode); end
    mtc0(5'd13, 32'hFFFF_FFFF);
    rd(5'd13, v); checks++; if (v !== 32'h0000_0300) begin errors++; $display("FAIL cause_wr got %h exp 00000300", v); end
    mtc0(5'd13, 32'h0);
    mtc0(5'd14, 32'h1234_5678);
    rd(5'd14, v); checks++; if (v !== 32'h1234_5678) begin errors++; $display("FAIL epc_wr got %h exp 12345678", v); end
    checks++; if (epc !== 32'h1234_5678) begin errors++; $display("FAIL epc_out got %h exp 12345678", epc); end
    mtc0(5'd5, 32'hFFFF_FFFF);
    rd(5'd5, v); checks++; if (v !== 32'h0) begin errors++; $display("FAIL unimpl_reg got %h exp 0", v); end
  endtask

  task automatic test_exc_priority();
    exc_valid = 4'b0110;
    exc_code  = {5'd0, 5'd12, 5'd10, 5'd0};
    exc_pc = 32'h0040_0020; exc_badaddr = 32'hDEAD_0000;
    tick();
    exc_valid = 4'b0001; exc_code = {5'd0, 5'd0, 5'd0, 5'd3};
    checks++; if ({redirect, flush} !== 2'b11) begin errors++; $display("FAIL trap_pulse got %b exp 11", {redirect, flush}); end
    checks++; if (redirect_pc !== 32'h80000180) begin errors++; $display("FAIL trap_rpc got %h exp 80000180", redirect_pc); end
    rd(5'd13, v); checks++; if (v !== 32'h28) begin errors++; $display("FAIL trap_cause got %h exp 00000028", v); end
    rd(5'd14, v); checks++; if (v !== 32'h0040_0020) begin errors++; $display("FAIL trap_epc got %h exp 00400020", v); end
    rd(5'd12, v); checks++; if (v !== 32'h2) begin errors++; $display("FAIL trap_exl got %h exp 00000002", v); end
    rd(5'd8, v);  checks++; if (v !== 32'hDEAD_0000) begin errors++; $display("FAIL trap_badv got %h exp dead0000", v); end
    tick();
    clear_ev();
    checks++; if ({redirect, flush} !== 2'b00) begin errors++; $display("FAIL trap_ignored got %b exp 00", {redirect, flush}); end
    rd(5'd13, v); checks++; if (v !== 32'h28) begin errors++; $display("FAIL trap_ignored_cause got %h exp 00000028", v); end
  endtask

  task automatic test_nested();
    exc_valid = 4'b1000; exc_code = {5'd13, 5'd0, 5'd0, 5'd0};
    exc_pc = 32'h0050_0000; exc_badaddr = 32'h0000_BEEF;
    tick();
    clear_ev();
    checks++; if (redirect !== 1'b1) begin errors++; $display("FAIL nest_redirect got %b exp 1", redirect); end
    rd(5'd13, v); checks++; if (v !== 32'h34) begin errors++; $display("FAIL nest_cause got %h exp 00000034", v); end
    rd(5'd14, v); checks++; if (v !== 32'h0040_0020) begin errors++; $display("FAIL nest_epc got %h exp 00400020", v); end
    rd(5'd8, v);  checks++; if (v !== 32'h0000_BEEF) begin errors++; $display("FAIL nest_badv got %h exp 0000beef", v); end
    tick();
  endtask

  task automatic test_eret();
    eret = 1'b1;
    tick();
    checks++; if ({redirect, flush} !== 2'b10) begin errors++; $display("FAIL eret_pulse got %b exp 10", {redirect, flush}); end
    checks++; if (redirect_pc !== 32'h0040_0020) begin errors++; $display("FAIL eret_rpc got %h exp 00400020", redirect_pc); end
    rd(5'd12, v); checks++; if (v !== 32'h0) begin errors++; $display("FAIL eret_status got %h exp 0", v); end
    tick();
    eret = 1'b0;
    checks++; if (redirect !== 1'b0) begin errors++; $display("FAIL eret_in_ret got %b exp 0", redirect); end
    eret = 1'b1; exc_valid = 4'b0001; exc_code = {5'd0, 5'd0, 5'd0, 5'd4}; exc_pc = 32'h0060_0000;
    tick();
    exc_valid = '0;
    checks++; if ({redirect, flush} !== 2'b11) begin errors++; $display("FAIL eret_exc_pulse got %b exp 11", {redirect, flush}); end
    checks++; if (redirect_pc !== 32'h80000180) begin errors++; $display("FAIL eret_exc_rpc got %h exp 80000180", redirect_pc); end
    rd(5'd13, v); checks++; if (v !== 32'h10) begin errors++; $display("FAIL eret_exc_cause got %h exp 00000010", v); end
    rd(5'd14, v); checks++; if (v !== 32'h0060_0000) begin errors++; $display("FAIL eret_exc_epc got %h exp 00600000", v); end
    tick();
    clear_ev();
    checks++; if (redirect !== 1'b0) begin errors++; $display("FAIL eret_in_trap got %b exp 0", redirect); end
    rd(5'd12, v); checks++; if (v !== 32'h2) begin errors++; $display("FAIL eret_exl_kept got %h exp 00000002", v); end
  endtask

  task automatic test_irq();
    logic seen;
    int   cnt;
    irq = 6'b000001;
    mtc0(5'd12, 32'h0000_0401);
    seen = 1'b0;
    for (int i = 0; i < 4 && !seen; i++) begin
      tick();
      seen = redirect;
    end
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL irq_trap got %b exp 1", seen); end
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL irq_flush got %b exp 1", flush); end
    rd(5'd13, v); checks++; if (v !== 32'h400) begin errors++; $display("FAIL irq_cause got %h exp 00000400", v); end
    rd(5'd12, v); checks++; if (v !== 32'h403) begin errors++; $display("FAIL irq_status got %h exp 00000403", v); end
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (redirect) cnt++;
    end
    checks++; if (cnt !== 0) begin errors++; $display("FAIL irq_exl_mask got %0d exp 0", cnt); end
    mtc0(5'd12, 32'h0000_0401);
    exc_valid = 4'b0100; exc_code = {5'd0, 5'd7, 5'd0, 5'd0};
    tick();
    clear_ev();
    rd(5'd13, v); checks++; if (v !== 32'h41C) begin errors++; $display("FAIL exc_beats_irq got %h exp 0000041c", v); end
    tick();
    irq = '0;
    mtc0(5'd12, 32'h0);
    tick();
  endtask

  task automatic test_collision();
    mt_en = 1'b1; wreg = 5'd14; wdata = 32'h1111_1111;
    exc_valid = 4'b0001; exc_code = {5'd0, 5'd0, 5'd0, 5'd5}; exc_pc = 32'h0070_0000;
    tick();
    mt_en = 1'b0; clear_ev();
    rd(5'd14, v); checks++; if (v !== 32'h0070_0000) begin errors++; $display("FAIL coll_epc got %h exp 00700000", v); end
    rd(5'd13, v); checks++; if (v !== 32'h14) begin errors++; $display("FAIL coll_cause got %h exp 00000014", v); end
    tick();
    mt_en = 1'b1; wreg = 5'd12; wdata = 32'h0000_FF11;
    exc_valid = 4'b0001; exc_code = {5'd0, 5'd0, 5'd0, 5'd6};
    tick();
    mt_en = 1'b0; clear_ev();
    rd(5'd12, v); checks++; if (v !== 32'h0000_FF13) begin errors++; $display("FAIL coll_status got %h exp 0000ff13", v); end
    checks++; if (kernel_mode !== 1'b1) begin errors++; $display("FAIL coll_kernel got %b exp 1", kernel_mode); end
    tick();
    mtc0(5'd12, 32'h0);
  endtask

  task automatic test_reset_in_trap();
    mtc0(5'd8, 32'h1357_9BDF);
    exc_valid = 4'b0010; exc_code = {5'd0, 5'd0, 5'd8, 5'd0}; exc_pc = 32'h0080_0000;
    tick();
    clear_ev();
    checks++; if (redirect !== 1'b1) begin errors++; $display("FAIL rt_pre_trap got %b exp 1", redirect); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if ({redirect, flush} !== 2'b00) begin errors++; $display("FAIL rt_cancel got %b exp 00", {redirect, flush}); end
    rd(5'd12, v); checks++; if (v !== 32'h2) begin errors++; $display("FAIL rt_status got %h exp 00000002", v); end
    rd(5'd13, v); checks++; if (v !== 32'h0) begin errors++; $display("FAIL rt_cause got %h exp 0", v); end
    rd(5'd14, v); checks++; if (v !== 32'h0) begin errors++; $display("FAIL rt_epc got %h exp 0", v); end
    rd(5'd8, v);  checks++; if (v !== 32'h0) begin errors++; $display("FAIL rt_badv got %h exp 0", v); end
    tick();
    checks++; if (redirect !== 1'b0) begin errors++; $display("FAIL rt_after got %b exp 0", redirect); end
  endtask

`ifdef COP0_TIMER_EN
  task automatic test_timer();
    logic seen;
    mtc0(5'd11, 32'd5);
    mtc0(5'd9, 32'd0);
    rd(5'd9, v); checks++; if (v !== 32'd0) begin errors++; $display("FAIL tmr_count_wr got %h exp 0", v); end
    tick(); tick(); tick();
    rd(5'd13, v); checks++; if (v[30] !== 1'b0) begin errors++; $display("FAIL tmr_early got %b exp 0", v[30]); end
    seen = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      tick();
      rd(5'd13, v);
      seen = v[30];
    end
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL tmr_ti got %b exp 1", seen); end
    checks++; if (v[15] !== 1'b1) begin errors++; $display("FAIL tmr_ip7 got %b exp 1", v[15]); end
    mtc0(5'd12, 32'h0000_8001);
    seen = 1'b0;
    for (int i = 0; i < 3 && !seen; i++) begin
      tick();
      seen = redirect;
    end
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL tmr_trap got %b exp 1", seen); end
    rd(5'd13, v); checks++; if (v[6:2] !== 5'd0) begin errors++; $display("FAIL tmr_code got %h exp 0", v[6:2]); end
    tick();
    mtc0(5'd11, 32'h100);
    rd(5'd13, v); checks++; if (v[30] !== 1'b0) begin errors++; $display("FAIL tmr_clear got %b exp 0", v[30]); end
  endtask
`else
  task automatic test_timer();
    mtc0(5'd11, 32'd5);
    mtc0(5'd9, 32'd7);
    rd(5'd9, v);  checks++; if (v !== 32'h0) begin errors++; $display("FAIL notmr_count got %h exp 0", v); end
    rd(5'd11, v); checks++; if (v !== 32'h0) begin errors++; $display("FAIL notmr_compare got %h exp 0", v); end
    for (int i = 0; i < 8; i++) tick();
    rd(5'd13, v); checks++; if (v[30] !== 1'b0) begin errors++; $display("FAIL notmr_ti got %b exp 0", v[30]); end
  endtask
`endif

  initial begin
    reset = 1'b1; mt_en = 1'b0; wreg = '0; wdata = '0; rreg = '0;
    exc_valid = '0; exc_code = '0; exc_pc = '0; exc_badaddr = '0; irq = '0; eret = 1'b0;
    tick();
    test_reset();
    test_regs();
    test_exc_priority();
    test_nested();
    test_eret();
    test_irq();
    test_collision();
    test_reset_in_trap();
    test_timer();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
